// File: rtl/eject_inject_sched.sv
// Per-node ejection/injection scheduler for the bufferless deflection router:
// ejects one local flit, injects one queued local flit, and tracks the golden epoch.
module eject_inject_sched #(
  parameter logic [3:0] NODE_ID    = 4'd0,
  parameter int         EPOCH      = 16,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] nin,
  input  logic [9:0] sin,
  input  logic [9:0] ein,
  input  logic [9:0] win,
  input  logic [9:0] inj_data,
  input  logic       inj_valid,
  output logic       inj_ready,
  output logic [9:0] nout,
  output logic [9:0] sout,
  output logic [9:0] eout,
  output logic [9:0] wout,
  output logic [9:0] lout,
  output logic [3:0] gold,
  output logic [3:0] golden_src
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int EPC_W = (EPOCH > 1) ? $clog2(EPOCH) : 1;

  logic [3:0][9:0]  slot_in, slot_mid, slot_nxt;
  logic [3:0]       cand, gcand, pick, empty, gold_nxt;
  logic [1:0]       ej_sel, inj_sel;
  logic             ej_valid, do_pop, do_push;
  logic [9:0]       lout_nxt;
  logic [4:0]       head;
  logic [4:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_nxt;
  logic [EPC_W-1:0] epoch_cnt;

  // Valid and source bits of a queued flit are replaced at injection time.
  logic unused_inj_bits;
  assign unused_inj_bits = ^{inj_data[9], inj_data[4:1]};

  assign slot_in = {win, ein, sin, nin};
  assign do_push = inj_valid && inj_ready;

  // Golden local candidates take precedence; ties resolve to the lowest slot index.
  always_comb begin
    cand     = '0;
    gcand    = '0;
    for (int i = 0; i < 4; i++) begin
      cand[i]  = slot_in[i][9] && (slot_in[i][8:5] == NODE_ID);
      gcand[i] = cand[i] && (slot_in[i][4:1] == golden_src);
    end
    pick     = (|gcand) ? gcand : cand;
    ej_valid = |pick;
    ej_sel   = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (pick[i]) ej_sel = 2'(i);
    lout_nxt = ej_valid ? slot_in[ej_sel] : 10'b0;
  end

  always_comb begin
    slot_mid = '0;
    empty    = '0;
    for (int i = 0; i < 4; i++) begin
      if (slot_in[i][9] && !(ej_valid && ej_sel == 2'(i)))
        slot_mid[i] = slot_in[i];
      empty[i] = !slot_mid[i][9];
    end
    do_pop  = (count != '0) && (|empty);
    inj_sel = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (empty[i]) inj_sel = 2'(i);
    head     = mem[rd_ptr];
    slot_nxt = slot_mid;
    gold_nxt = '0;
    for (int i = 0; i < 4; i++) begin
      if (do_pop && inj_sel == 2'(i))
        slot_nxt[i] = {1'b1, head[4:1], NODE_ID, head[0]};
      gold_nxt[i] = slot_nxt[i][9] && (slot_nxt[i][4:1] == golden_src);
    end
  end

  always_comb begin
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // NOTE: reset is sampled on the clock edge only, so it stays out of the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      epoch_cnt  <= '0;
      golden_src <= 4'd0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      inj_ready  <= 1'b0;
      nout       <= 10'b0;
      sout       <= 10'b0;
      eout       <= 10'b0;
      wout       <= 10'b0;
      lout       <= 10'b0;
      gold       <= 4'b0;
    end else begin
      if (epoch_cnt == EPC_W'(EPOCH - 1)) begin
        epoch_cnt  <= '0;
        golden_src <= golden_src + 4'd1;
      end else begin
        epoch_cnt  <= epoch_cnt + EPC_W'(1);
      end
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_nxt;
      inj_ready <= (count_nxt != CNT_W'(FIFO_DEPTH));
      nout      <= slot_nxt[0];
      sout      <= slot_nxt[1];
      eout      <= slot_nxt[2];
      wout      <= slot_nxt[3];
      lout      <= lout_nxt;
      gold      <= gold_nxt;
    end
  end

  // NOTE: queue storage has no reset; an entry is only read once count shows it was written.
  always_ff @(posedge clk) begin
    if (rst_n && do_push)
      mem[wr_ptr] <= {inj_data[8:5], inj_data[0]};
  end
endmodule

// File: tb/tb_eject_inject_sched.sv
// Scoreboard bench for eject_inject_sched: stimulus queues hand-computed
// expectations, a negedge monitor pops and compares them against the outputs.
module tb_eject_inject_sched;
  localparam logic [3:0] NODE = 4'd3;
  localparam logic [9:0] Z    = 10'd0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] nin = Z, sin = Z, ein = Z, win = Z, inj_data = Z;
  logic       inj_valid = 1'b0;
  logic       inj_ready;
  logic [9:0] nout, sout, eout, wout, lout;
  logic [3:0] gold, golden_src;

  eject_inject_sched #(.NODE_ID(NODE), .EPOCH(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .nin(nin), .sin(sin), .ein(ein), .win(win),
    .inj_data(inj_data), .inj_valid(inj_valid), .inj_ready(inj_ready),
    .nout(nout), .sout(sout), .eout(eout), .wout(wout),
    .lout(lout), .gold(gold), .golden_src(golden_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [95:0] name;
    logic [9:0]  n, s, e, w, l;
    logic [3:0]  g;
    logic        chk_rdy, rdy, chk_gs;
    logic [3:0]  gs;
  } exp_t;

  exp_t sbq[$];
  exp_t mx;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input logic [95:0] nm, input logic [79:0] fld,
                       input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %0s.%0s: got %0h, expected %0h", nm, fld, act, req);
    end
  endtask

  // Valid flit toward dest from src.
  function automatic logic [9:0] fl(input logic [3:0] d, input logic [3:0] s, input logic p);
    return {1'b1, d, s, p};
  endfunction

  // Queue payload with junk in the bits the DUT must ignore.
  function automatic logic [9:0] qd(input logic [3:0] d, input logic p);
    return {1'b1, d, 4'hA, p};
  endfunction

  // Flit as it must leave after injection.
  function automatic logic [9:0] ij(input logic [3:0] d, input logic p);
    return {1'b1, d, NODE, p};
  endfunction

  function automatic exp_t mk(input logic [95:0] nm, input logic [9:0] n, s, e, w, l,
                              input logic [3:0] g);
    exp_t x;
    x.due = 0; x.name = nm;
    x.n = n; x.s = s; x.e = e; x.w = w; x.l = l; x.g = g;
    x.chk_rdy = 1'b0; x.rdy = 1'b0; x.chk_gs = 1'b0; x.gs = 4'd0;
    return x;
  endfunction

  function automatic exp_t with_rdy(input exp_t x, input logic r);
    exp_t y;
    y = x; y.chk_rdy = 1'b1; y.rdy = r;
    return y;
  endfunction

  function automatic exp_t with_gs(input exp_t x, input logic [3:0] g);
    exp_t y;
    y = x; y.chk_gs = 1'b1; y.gs = g;
    return y;
  endfunction

  // Drive one input cycle; its outputs are due after the next clock edge.
  task automatic step(input logic [9:0] n, s, e, w, d, input logic v, input exp_t x);
    nin = n; sin = s; ein = e; win = w; inj_data = d; inj_valid = v;
    x.due = cyc + 1;
    sbq.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [9:0] n, s, e, w);
    rst_n = 1'b0;
    step(n, s, e, w, Z, 1'b0, with_gs(with_rdy(mk("reset", Z, Z, Z, Z, Z, 4'd0), 1'b0), 4'd0));
    rst_n = 1'b1;
    step(Z, Z, Z, Z, Z, 1'b0, with_rdy(mk("release", Z, Z, Z, Z, Z, 4'd0), 1'b1));
  endtask

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      mx = sbq.pop_front();
      if (mx.due < cyc) begin
        check(mx.name, "due", cyc, mx.due);
      end else begin
        check(mx.name, "nout", {22'd0, nout}, {22'd0, mx.n});
        check(mx.name, "sout", {22'd0, sout}, {22'd0, mx.s});
        check(mx.name, "eout", {22'd0, eout}, {22'd0, mx.e});
        check(mx.name, "wout", {22'd0, wout}, {22'd0, mx.w});
        check(mx.name, "lout", {22'd0, lout}, {22'd0, mx.l});
        check(mx.name, "gold", {28'd0, gold}, {28'd0, mx.g});
        if (mx.chk_rdy) check(mx.name, "inj_ready", {31'd0, inj_ready}, {31'd0, mx.rdy});
        if (mx.chk_gs)  check(mx.name, "golden_src", {28'd0, golden_src}, {28'd0, mx.gs});
      end
    end
  end

  initial begin
    logic [9:0] fn, fs, fe, fw;
    fn = fl(4'd5, 4'd8, 1'b0);
    fs = fl(4'd6, 4'd9, 1'b1);
    fe = fl(4'd7, 4'd10, 1'b0);
    fw = fl(4'd8, 4'd11, 1'b1);

    // Reset with a local flit on the inputs, then idle through 16 epochs.
    rst_n = 1'b0;
    step(fl(NODE, 4'd5, 1'b1), Z, Z, Z, Z, 1'b0,
         with_gs(with_rdy(mk("in_reset", Z, Z, Z, Z, Z, 4'd0), 1'b0), 4'd0));
    step(fl(NODE, 4'd5, 1'b1), Z, Z, Z, Z, 1'b0,
         with_gs(with_rdy(mk("in_reset", Z, Z, Z, Z, Z, 4'd0), 1'b0), 4'd0));
    rst_n = 1'b1;
    for (int j = 1; j <= 256; j++) begin
      exp_t x;
      x = mk("idle", Z, Z, Z, Z, Z, 4'd0);
      if (j == 1)   x = with_rdy(x, 1'b1);
      if (j == 15)  x = with_gs(x, 4'd0);
      if (j == 16)  x = with_gs(x, 4'd1);
      if (j == 17)  x = with_gs(x, 4'd1);
      if (j == 255) x = with_gs(x, 4'd15);
      if (j == 256) x = with_gs(x, 4'd0);
      step(Z, Z, Z, Z, Z, 1'b0, x);
    end

    // Golden candidate beats a lower-index local; then plain lowest-index and hygiene.
    do_reset(Z, Z, Z, Z);
    step(fl(NODE, 4'd5, 1'b0), fl(4'd7, 4'd9, 1'b1), fl(NODE, 4'd0, 1'b1), Z, Z, 1'b0,
         mk("golden_ej", fl(NODE, 4'd5, 1'b0), fl(4'd7, 4'd9, 1'b1), Z, Z,
            fl(NODE, 4'd0, 1'b1), 4'b0000));
    step(fl(NODE, 4'd5, 1'b0), 10'h1FF, fl(4'd9, 4'd0, 1'b1), fl(NODE, 4'd6, 1'b1), Z, 1'b0,
         mk("lowest_ej", Z, Z, fl(4'd9, 4'd0, 1'b1), fl(NODE, 4'd6, 1'b1),
            fl(NODE, 4'd5, 1'b0), 4'b0100));

    // Fill the queue behind full non-local traffic, then drain with wrap-around.
    do_reset(fn, fs, fe, fw);
    step(fn, fs, fe, fw, qd(4'd4, 1'b1), 1'b1, with_rdy(mk("push1", fn, fs, fe, fw, Z, 4'd0), 1'b1));
    step(fn, fs, fe, fw, qd(4'd5, 1'b0), 1'b1, with_rdy(mk("push2", fn, fs, fe, fw, Z, 4'd0), 1'b1));
    step(fn, fs, fe, fw, qd(4'd6, 1'b1), 1'b1, with_rdy(mk("push3", fn, fs, fe, fw, Z, 4'd0), 1'b1));
    step(fn, fs, fe, fw, qd(4'd9, 1'b0), 1'b1, with_rdy(mk("push4_full", fn, fs, fe, fw, Z, 4'd0), 1'b0));
    step(fn, fs, fe, fw, qd(4'd15, 1'b1), 1'b1, with_rdy(mk("full_hold", fn, fs, fe, fw, Z, 4'd0), 1'b0));
    step(fn, fs, fe, Z, Z, 1'b0, with_rdy(mk("inj_w", fn, fs, fe, ij(4'd4, 1'b1), Z, 4'd0), 1'b1));
    step(Z, Z, Z, Z, qd(4'd10, 1'b1), 1'b1, with_rdy(mk("inj_push2", ij(4'd5, 1'b0), Z, Z, Z, Z, 4'd0), 1'b1));
    step(Z, Z, Z, Z, qd(4'd11, 1'b0), 1'b1, with_rdy(mk("inj_push3", ij(4'd6, 1'b1), Z, Z, Z, Z, 4'd0), 1'b1));
    step(Z, Z, Z, Z, Z, 1'b0, with_rdy(mk("inj4", ij(4'd9, 1'b0), Z, Z, Z, Z, 4'd0), 1'b1));
    step(Z, Z, Z, Z, Z, 1'b0, mk("inj_wrap5", ij(4'd10, 1'b1), Z, Z, Z, Z, 4'd0));
    step(Z, Z, Z, Z, Z, 1'b0, mk("inj_wrap6", ij(4'd11, 1'b0), Z, Z, Z, Z, 4'd0));
    step(Z, Z, Z, Z, Z, 1'b0, with_rdy(mk("drained", Z, Z, Z, Z, Z, 4'd0), 1'b1));

    // Four valid slots with one local: eject it and inject into the vacated slot.
    do_reset(Z, Z, Z, Z);
    step(fn, fs, fe, fw, qd(4'd12, 1'b1), 1'b1, with_rdy(mk("pushq", fn, fs, fe, fw, Z, 4'd0), 1'b1));
    step(fn, fl(NODE, 4'd9, 1'b1), fe, fw, Z, 1'b0,
         mk("ej_inj_s", fn, ij(4'd12, 1'b1), fe, fw, fl(NODE, 4'd9, 1'b1), 4'd0));
    step(Z, Z, Z, Z, Z, 1'b0, mk("after_ej", Z, Z, Z, Z, Z, 4'd0));

    // A push into an empty queue injects two edges later, never one.
    do_reset(Z, Z, Z, Z);
    step(Z, Z, Z, Z, qd(4'd13, 1'b0), 1'b1, with_rdy(mk("push_empty", Z, Z, Z, Z, Z, 4'd0), 1'b1));
    step(Z, Z, Z, Z, Z, 1'b0, mk("inj_2edge", ij(4'd13, 1'b0), Z, Z, Z, Z, 4'd0));
    step(Z, Z, Z, Z, Z, 1'b0, mk("idle_after", Z, Z, Z, Z, Z, 4'd0));

    // Mid-stream reset discards three queued flits and restarts the epoch.
    do_reset(Z, Z, Z, Z);
    step(fn, fs, fe, fw, qd(4'd1, 1'b1), 1'b1, mk("stale1", fn, fs, fe, fw, Z, 4'd0));
    step(fn, fs, fe, fw, qd(4'd2, 1'b0), 1'b1, mk("stale2", fn, fs, fe, fw, Z, 4'd0));
    step(fn, fs, fe, fw, qd(4'd4, 1'b1), 1'b1, mk("stale3", fn, fs, fe, fw, Z, 4'd0));
    rst_n = 1'b0;
    step(fn, fs, fe, fw, qd(4'd14, 1'b1), 1'b1,
         with_gs(with_rdy(mk("mid_reset", Z, Z, Z, Z, Z, 4'd0), 1'b0), 4'd0));
    rst_n = 1'b1;
    for (int j = 1; j <= 17; j++) begin
      exp_t x;
      x = mk("post_reset", Z, Z, Z, Z, Z, 4'd0);
      if (j == 1)  x = with_rdy(x, 1'b1);
      if (j == 15) x = with_gs(x, 4'd0);
      if (j == 16) x = with_gs(x, 4'd1);
      step(Z, Z, Z, Z, Z, 1'b0, x);
    end

    for (int k = 0; k < 5 && sbq.size() > 0; k++) @(negedge clk);
    #1;
    check("scoreboard", "left", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/eject_inject_sched.md
# eject_inject_sched

Per-node ejection/injection scheduler for the bufferless deflection router. It sits between the stage-1 pipeline registers and the first combinational permutation stage. Each cycle it:
- ejects at most one locally-destined flit;
- injects at most one queued local (cache-miss) flit into a free slot;
- maintains the golden-epoch counter that marks which flits receive golden priority downstream.

All outputs are registered, one cycle after the inputs.

## Interface
Parameters:
- NODE_ID, 4'd0, this router's node id; matched against the flit dest field.
- EPOCH, 16, cycles per golden epoch; must be ≥ 2.
- FIFO_DEPTH, 4, local injection queue entries; must be a power of 2.

Ports:
- clk  in  1  router clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- nin, sin, ein, win  in  10 each  stage-1 flits. Flit format: [9] valid, [8:5] dest, [4:1] src, [0] payload.
- inj_data  in  10  local flit to queue; bits [9] and [4:1] are ignored.
- inj_valid  in  1  inj_data offered this cycle.
- inj_ready  out  1  queue can accept a flit.
- nout, sout, eout, wout  out  10 each  flits to the permutation stage; an empty slot is 10'b0.
- lout  out  10  ejected flit; lout[9] = eject valid.
- gold  out  4  per-slot golden flag, ordered {w,e,s,n}.
- golden_src  out  4  current golden source id.

## Operation
**Golden epoch**
- epoch_cnt runs 0..EPOCH-1. On the cycle epoch_cnt==EPOCH-1 it wraps to 0 and golden_src increments mod 16 (15 → 0).
- A flit is golden when valid=1 and src==golden_src, using the golden_src value of the current cycle.

**Ejection** (combinational on the inputs)
- Candidates: slots with valid=1 and dest==NODE_ID.
- If any candidate is golden, eject the lowest-index golden candidate. Otherwise eject the lowest-index candidate. Slot order: N=0, S=1, E=2, W=3.
- The ejected slot becomes empty. Other local candidates stay in their slots and are deflected downstream.
- If there is no candidate, lout = 0.

**Injection queue**
- Circular FIFO of FIFO_DEPTH entries with an occupancy count.
- Push when inj_valid && inj_ready.
- inj_ready = !full, taken from the registered count; no combinational path from inj_valid.

**Injection**
- Condition: FIFO not empty, evaluated on the registered count, and at least one slot is empty after ejection, including the slot just vacated by ejection.
- Action: pop the head and place it in the lowest-index empty slot.
- The injected flit is rewritten with [9]=1 and [4:1]=NODE_ID; dest and payload are kept.
- The injected flit's gold bit is (NODE_ID==golden_src).

**Output hygiene**
- Any input slot with valid=0 is output as 10'b0 regardless of its other bits.
- Non-ejected valid flits pass unchanged in their own slot.

**Reset** (rst_n low at a clk edge)
- All outputs 0, including inj_ready=0 and golden_src=0.
- FIFO emptied and epoch_cnt=0.
- inj_ready rises to 1 on the first edge with rst_n high.
- Reset asserted mid-operation discards queued flits and in-flight outputs; it does not complete partial transfers.

## Timing
- Latency: inputs at edge k appear on nout/sout/eout/wout/lout/gold after edge k+1. The schedule is fixed; there are no bubbles or stalls.
- Push-to-inject: a flit pushed at edge k is first eligible for injection in the cycle after edge k, with outputs at edge k+2. A push into an empty FIFO cannot inject in the same cycle.
- Simultaneous push and pop:
  - Allowed when count is between 1 and FIFO_DEPTH-1; count is unchanged.
  - At full, inj_ready=0, so only pops occur.
  - inj_ready rises the cycle after the pop that leaves count < FIFO_DEPTH.
- All four slots valid and no ejection: no injection; the queue holds.
- Four slots valid with one ejected: injection proceeds into the vacated slot.
- Pointer wrap-around at FIFO_DEPTH-1 → 0 must preserve FIFO order.
- golden_src change: takes effect on the first cycle with epoch_cnt==0. Flits evaluated in the wrap cycle use the old golden_src.

## Test plan
- Reset, then idle. Expected: all outputs 0 during reset; inj_ready=1 one edge after release; golden_src=1 after exactly EPOCH cycles; golden_src 15 → 0 after 16 epochs.
- NODE_ID=3, golden_src=0. Input nin=dest3/src5, ein=dest3/src0, sin=dest7. Expected: lout = the ein flit (golden wins); eout=0; nout and sout pass; gold=4'b0000 on outputs.
- Push 4 flits with all slots full and non-local. Expected: inj_ready drops after the 4th push. Then free wout only. Expected: head flit appears on wout with src=NODE_ID and bit9=1; inj_ready=1 on the next cycle.
- All slots valid with one local (dest=NODE_ID on sin), queue non-empty. Expected: sin flit ejected on lout; head injected into the S slot in the same output cycle.
- Push into an empty queue with all slots empty. Expected: injection occurs on nout two edges after the push, not one.
- Assert rst_n low for 1 cycle with 3 flits queued mid-stream. Expected: queue empty; outputs 0; epoch restarts at 0; no stale flit is ever injected.
